// File: rtl/frac_baud_gen.sv
// Fractional baud generator.
//
// Produces an oversample tick (os_tick) whose average period is
// div_int + 1 + div_frac / 2^FRAC_WIDTH clock cycles. It also produces a bit
// tick (bit_tick) on every OVERSAMPLE-th os_tick. The fractional part is
// accumulated once per os period. Its carry stretches the following period by
// one cycle, so the rate never drifts.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   en        count enable; low freezes all counting state
//   load      one-cycle pulse: capture div_int/div_frac and restart all counters
//   div_int   integer divisor; base os period is div_int + 1 cycles
//   div_frac  fractional divisor, added to the accumulator once per os period
//   os_tick   registered one-cycle pulse per oversample period
//   bit_tick  registered one-cycle pulse, coincident with every OVERSAMPLE-th os_tick

module frac_baud_gen #(
  parameter int unsigned INT_WIDTH  = 16,
  parameter int unsigned FRAC_WIDTH = 4,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  load,
  input  logic [INT_WIDTH-1:0]  div_int,
  input  logic [FRAC_WIDTH-1:0] div_frac,
  output logic                  os_tick,
  output logic                  bit_tick
);

  localparam int unsigned OsW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OsW-1:0] OsLast = OsW'(OVERSAMPLE - 1);
  localparam logic [OsW-1:0] OsOne  = OsW'(1);
  localparam logic [INT_WIDTH:0] CntOne = (INT_WIDTH + 1)'(1);

  logic [INT_WIDTH-1:0]  div_int_q, div_int_d;
  logic [FRAC_WIDTH-1:0] div_frac_q, div_frac_d;
  // One bit wider than the divisor so that limit = all-ones + carry still fits.
  logic [INT_WIDTH:0]    cnt_q, cnt_d;
  logic [FRAC_WIDTH-1:0] acc_q, acc_d;
  logic                  carry_pend_q, carry_pend_d;
  logic [OsW-1:0]        os_cnt_q, os_cnt_d;
  logic                  os_tick_q, os_tick_d;
  logic                  bit_tick_q, bit_tick_d;

  logic [INT_WIDTH:0]    limit;
  logic [FRAC_WIDTH:0]   frac_sum;
  logic                  wrap;

  assign limit    = {1'b0, div_int_q} + {{INT_WIDTH{1'b0}}, carry_pend_q};
  assign frac_sum = {1'b0, acc_q} + {1'b0, div_frac_q};
  assign wrap     = (cnt_q == limit);

  always_comb begin
    div_int_d    = div_int_q;
    div_frac_d   = div_frac_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    carry_pend_d = carry_pend_q;
    os_cnt_d     = os_cnt_q;
    // Ticks are pulses; they drop unless this edge wraps.
    os_tick_d    = 1'b0;
    bit_tick_d   = 1'b0;

    if (load) begin
      // Load beats enable and suppresses any tick due on this edge.
      div_int_d    = div_int;
      div_frac_d   = div_frac;
      cnt_d        = '0;
      acc_d        = '0;
      carry_pend_d = 1'b0;
      os_cnt_d     = '0;
    end else if (en) begin
      if (wrap) begin
        cnt_d        = '0;
        acc_d        = frac_sum[FRAC_WIDTH-1:0];
        // The carry lengthens only the period that starts now.
        carry_pend_d = frac_sum[FRAC_WIDTH];
        os_tick_d    = 1'b1;
        if (os_cnt_q == OsLast) begin
          os_cnt_d   = '0;
          bit_tick_d = 1'b1;
        end else begin
          os_cnt_d   = os_cnt_q + OsOne;
        end
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_int_q    <= '0;
      div_frac_q   <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      carry_pend_q <= 1'b0;
      os_cnt_q     <= '0;
      os_tick_q    <= 1'b0;
      bit_tick_q   <= 1'b0;
    end else begin
      div_int_q    <= div_int_d;
      div_frac_q   <= div_frac_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      carry_pend_q <= carry_pend_d;
      os_cnt_q     <= os_cnt_d;
      os_tick_q    <= os_tick_d;
      bit_tick_q   <= bit_tick_d;
    end
  end

  assign os_tick  = os_tick_q;
  assign bit_tick = bit_tick_q;

endmodule

// File: tb/tb_frac_baud_gen.sv
module tb_frac_baud_gen;

  logic        clk;
  logic        reset;
  logic        en;
  logic        load;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        os_tick;
  logic        bit_tick;

  int errors = 0;
  int checks = 0;

  frac_baud_gen #(
    .INT_WIDTH (16),
    .FRAC_WIDTH(4),
    .OVERSAMPLE(16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .div_int (div_int),
    .div_frac(div_frac),
    .os_tick (os_tick),
    .bit_tick(bit_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic        en;
    logic [15:0] di;
    logic [3:0]  df;
    logic        exp_os;
    logic        exp_bit;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input logic ld, input logic e, input logic [15:0] di, input logic [3:0] df,
                      input logic eo, input logic eb);
    vec_t v;
    v.load = ld; v.en = e; v.di = di; v.df = df; v.exp_os = eo; v.exp_bit = eb;
    vq.push_back(v);
  endtask

  task automatic do_load(input logic [15:0] di, input logic [3:0] df);
    div_int = di; div_frac = df; load = 1'b1; en = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Runs n enabled edges and summarises the tick activity seen.
  task automatic run(input int n, output int os_n, output int first_os, output int bit_n,
                     output int last_bit, output int orphan);
    os_n = 0; first_os = -1; bit_n = 0; last_bit = -1; orphan = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      if (os_tick) begin
        os_n++;
        if (first_os < 0) first_os = k;
      end
      if (bit_tick) begin
        bit_n++;
        last_bit = k;
        if (!os_tick) orphan++;
      end
    end
  endtask

  initial begin
    int os_n, first_os, bit_n, last_bit, orphan;
    int last_os, idx, edge_n, exp_p;
    bit seen;

    reset = 1'b1; en = 1'b0; load = 1'b0; div_int = '0; div_frac = '0;
    step(); step();
    chk("reset_os", int'(os_tick), 0);
    chk("reset_bit", int'(bit_tick), 0);
    reset = 1'b0;
    step();

    // Vectors: edge index counted from each load.
    addv(1, 1, 5, 0, 0, 0);
    for (int i = 0; i < 5; i++) addv(0, 1, 7, 3, 0, 0);  // unloaded changes ignored
    addv(0, 1, 7, 3, 1, 0);
    for (int i = 0; i < 3; i++) addv(0, 1, 5, 0, 0, 0);
    for (int i = 0; i < 3; i++) addv(0, 0, 5, 0, 0, 0);  // frozen at cnt=3
    addv(0, 1, 5, 0, 0, 0);
    addv(0, 1, 5, 0, 0, 0);
    addv(0, 1, 5, 0, 1, 0);
    for (int i = 0; i < 5; i++) addv(0, 1, 5, 0, 0, 0);
    addv(1, 1, 2, 0, 0, 0);                              // load on due edge
    addv(0, 1, 2, 0, 0, 0); addv(0, 1, 2, 0, 0, 0); addv(0, 1, 2, 0, 1, 0);
    addv(0, 1, 2, 0, 0, 0); addv(0, 1, 2, 0, 0, 0); addv(0, 1, 2, 0, 1, 0);
    addv(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) addv(0, 1, 0, 0, 1, 0);
    addv(0, 0, 0, 0, 0, 0);
    addv(0, 1, 0, 0, 1, 0);
    addv(1, 1, 0, 8, 0, 0);                              // periods alternate 1,2
    addv(0, 1, 0, 8, 1, 0); addv(0, 1, 0, 8, 1, 0); addv(0, 1, 0, 8, 0, 0);
    addv(0, 1, 0, 8, 1, 0); addv(0, 1, 0, 8, 1, 0); addv(0, 1, 0, 8, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      load = vq[i].load; en = vq[i].en; div_int = vq[i].di; div_frac = vq[i].df;
      step();
      chk($sformatf("vec%0d_os", i), int'(os_tick), int'(vq[i].exp_os));
      chk($sformatf("vec%0d_bit", i), int'(bit_tick), int'(vq[i].exp_bit));
    end
    load = 1'b0;

    // Integer divisor: 16 os ticks and one bit tick in 96 cycles.
    do_load(16'd5, 4'd0);
    run(96, os_n, first_os, bit_n, last_bit, orphan);
    chk("int_first_os", first_os, 6);
    chk("int_os_count", os_n, 16);
    chk("int_bit_count", bit_n, 1);
    chk("int_bit_at", last_bit, 96);
    chk("int_orphan_bit", orphan, 0);

    // Fractional 53 + 4/16: long period after every 4th carry-producing wrap.
    do_load(16'd53, 4'd4);
    last_os = 0; idx = 0; edge_n = 0;
    while (idx < 16 && edge_n < 2000) begin
      step();
      edge_n++;
      if (os_tick) begin
        idx++;
        exp_p = (idx >= 5 && ((idx - 5) % 4) == 0) ? 55 : 54;
        chk($sformatf("frac_period%0d", idx), edge_n - last_os, exp_p);
        if (idx == 16) chk("frac_bit16", int'(bit_tick), 1);
        else if (bit_tick) chk("frac_early_bit", idx, 16);
        last_os = edge_n;
      end
    end
    chk("frac_ticks_seen", idx, 16);
    chk("frac_span16", last_os, 867);

    // Enable gating at cnt=20.
    do_load(16'd53, 4'd0);
    run(20, os_n, first_os, bit_n, last_bit, orphan);
    en = 1'b0;
    run(10, os_n, first_os, bit_n, last_bit, orphan);
    chk("gate_os_while_low", os_n, 0);
    en = 1'b1;
    run(40, os_n, first_os, bit_n, last_bit, orphan);
    chk("gate_resume_first", first_os, 34);

    // Reload to 9: bit tick lands on the 16th os tick after the load.
    do_load(16'd9, 4'd0);
    run(160, os_n, first_os, bit_n, last_bit, orphan);
    chk("reload_first_os", first_os, 10);
    chk("reload_os_count", os_n, 16);
    chk("reload_bit_at", last_bit, 160);

    // Async reset while os_tick is continuously high.
    do_load(16'd0, 4'd0);
    step();
    chk("pre_reset_os", int'(os_tick), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_os", int'(os_tick), 0);
    chk("async_reset_bit", int'(bit_tick), 0);
    @(negedge clk);
    reset = 1'b0;
    run(4, os_n, first_os, bit_n, last_bit, orphan);
    chk("post_reset_os_every_cycle", os_n, 4);

    // Max divisor: period of 65536 cycles without overflow.
    do_load(16'hFFFF, 4'd0);
    edge_n = 0; seen = 1'b0;
    while (!seen && edge_n < 70000) begin
      step();
      edge_n++;
      if (os_tick) seen = 1'b1;
    end
    chk("max_div_period", edge_n, 65536);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
